// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_dm_pkg;

    localparam int unsigned ICACHE_INDEX_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        ICACHE_IDLE   = 2'd0,
        ICACHE_MISS   = 2'd1,
        ICACHE_REFILL = 2'd2
    } icache_state_e;

endpackage

// Address-field extraction: word-aligned fetch address split into tag and index.
`ifndef ICACHE_TAG
`define ICACHE_TAG(a, aw, iw) a[(aw)-1:(iw)+2]
`endif
`ifndef ICACHE_INDEX
`define ICACHE_INDEX(a, iw) a[(iw)+1:2]
`endif

// File: rtl/icache_dm_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Count up on inc_i until saturated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped blocking instruction cache, one word per line, flop storage.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W_DEFAULT,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_inst_en_i,
    input  logic [ADDR_W-1:0] cpu_inst_addr_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              cpu_inst_valid_o,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam int unsigned LINES = 2 ** INDEX_W;

    icache_state_e     state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              drop_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [INDEX_W-1:0] fill_idx;
    logic               lookup;
    logic               hit;
    logic               miss;
    logic               fill_we;

    // Byte-offset bits of the fetch address carry no information.
    logic unused_addr;
    assign unused_addr = ^cpu_inst_addr_i[1:0];

    assign req_tag  = `ICACHE_TAG(cpu_inst_addr_i, ADDR_W, INDEX_W);
    assign req_idx  = `ICACHE_INDEX(cpu_inst_addr_i, INDEX_W);
    assign fill_idx = `ICACHE_INDEX(mem_addr_q, INDEX_W);

    // Lookup is gated by rst so stall/valid drop the instant reset asserts.
    assign lookup  = cpu_inst_en_i & rst & (state_q == ICACHE_IDLE);
    assign hit     = lookup & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign miss    = lookup & ~hit;
    assign fill_we = (state_q == ICACHE_MISS) & mem_ack_i & ~drop_q;

    // Fetch-side outputs: zero-latency hit data, stall from the miss cycle onward.
    always_comb begin
        cpu_inst_valid_o = hit;
        cpu_inst_o       = hit ? data_q[req_idx] : '0;
        stall_o          = miss | (state_q != ICACHE_IDLE);
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // Refill FSM with registered bus request, latched address and drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ICACHE_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (miss) begin
                        state_q    <= ICACHE_MISS;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {cpu_inst_addr_i[ADDR_W-1:2], 2'b00};
                        // A flush alongside the miss makes this fill stale.
                        drop_q     <= flush_i;
                    end
                end
                ICACHE_MISS: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    state_q <= ICACHE_IDLE;
                    drop_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ICACHE_IDLE;
                    mem_req_q <= 1'b0;
                    drop_q    <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: flush wins over a same-cycle refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= `ICACHE_TAG(mem_addr_q, ADDR_W, INDEX_W);
            data_q[fill_idx] <= mem_rdata_i;
        end
    end

    sat_counter32 u_hit_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (hit),
        .cnt_o  (hit_cnt_o)
    );

    sat_counter32 u_miss_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (miss),
        .cnt_o  (miss_cnt_o)
    );

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm against a line-level behavioural model.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        ivalid;
    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] maddr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: 64 one-word lines plus the two event counts.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    icache_dm dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_inst_en_i    (en),
        .cpu_inst_addr_i  (addr),
        .cpu_inst_o       (inst),
        .cpu_inst_valid_o (ivalid),
        .stall_o          (stall),
        .flush_i          (flush),
        .mem_req_o        (req),
        .mem_addr_o       (maddr),
        .mem_ack_i        (ack),
        .mem_rdata_i      (rdata),
        .hit_cnt_o        (hit_cnt),
        .miss_cnt_o       (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 8;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // One complete fetch: lookup, any refills, re-lookup until the hit returns.
    // flush_cyc: -1 none, 0 lookup cycle, k>=1 the k-th cycle spent in MISS.
    task automatic do_fetch(input logic [31:0] a, input int delay, input logic [31:0] d,
                            input int flush_cyc, output int stalls, output int reqs,
                            output int req_cycles);
        int  ix;
        bit  done;
        bit  drop;
        int  fc;
        ix = idx_of(a);
        done = 1'b0;
        stalls = 0;
        reqs = 0;
        req_cycles = 0;
        en = 1'b1;
        addr = a;
        for (int attempt = 0; attempt < 4 && !done; attempt++) begin
            fc = (attempt == 0) ? flush_cyc : -1;
            flush = (fc == 0);
            #1;
            if (m_valid[ix] && m_tag[ix] == tag_of(a)) begin
                checks++;
                if (ivalid !== 1'b1 || inst !== m_data[ix] || stall !== 1'b0 || req !== 1'b0) begin
                    errors++;
                    $display("FAIL hit_lookup a=%h got v=%b d=%h st=%b rq=%b want v=1 d=%h st=0 rq=0",
                             a, ivalid, inst, stall, req, m_data[ix]);
                end
                @(posedge clk);
                m_hits = sat_inc(m_hits);
                if (flush) model_flush();
                @(negedge clk);
                flush = 1'b0;
                done = 1'b1;
            end else begin
                checks++;
                if (ivalid !== 1'b0 || stall !== 1'b1 || req !== 1'b0 ||
                    hit_cnt !== m_hits || miss_cnt !== m_misses) begin
                    errors++;
                    $display("FAIL miss_lookup a=%h got v=%b st=%b rq=%b h=%0d m=%0d want 0 1 0 %0d %0d",
                             a, ivalid, stall, req, hit_cnt, miss_cnt, m_hits, m_misses);
                end
                stalls++;
                drop = flush;
                @(posedge clk);
                m_misses = sat_inc(m_misses);
                if (flush) model_flush();
                @(negedge clk);
                reqs++;
                for (int k = 0; k <= delay; k++) begin
                    flush = (fc == k + 1);
                    ack   = (k == delay);
                    rdata = ack ? d : $urandom;
                    #1;
                    checks++;
                    if (req !== 1'b1 || stall !== 1'b1 || maddr !== {a[31:2], 2'b00} ||
                        ivalid !== 1'b0) begin
                        errors++;
                        $display("FAIL miss_wait a=%h got rq=%b st=%b ma=%h v=%b want 1 1 %h 0",
                                 a, req, stall, maddr, ivalid, {a[31:2], 2'b00});
                    end
                    stalls++;
                    req_cycles++;
                    if (flush) drop = 1'b1;
                    @(posedge clk);
                    if (flush) begin
                        model_flush();
                    end else if (ack && !drop) begin
                        m_valid[ix] = 1'b1;
                        m_tag[ix]   = tag_of(a);
                        m_data[ix]  = d;
                    end
                    @(negedge clk);
                end
                ack = 1'b0;
                flush = 1'b0;
                #1;
                checks++;
                if (stall !== 1'b1 || req !== 1'b0 || ivalid !== 1'b0) begin
                    errors++;
                    $display("FAIL refill_cycle a=%h got st=%b rq=%b v=%b want 1 0 0",
                             a, stall, req, ivalid);
                end
                stalls++;
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL fetch_timeout a=%h got no hit after 4 lookups want hit", a);
        end
        en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b0;
        addr = '0;
        flush = 1'b0;
        ack = 1'b0;
        rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req !== 1'b0 || stall !== 1'b0 || ivalid !== 1'b0 || inst !== '0 || maddr !== '0 ||
            hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got rq=%b st=%b v=%b d=%h ma=%h h=%0d m=%0d want all 0",
                     req, stall, ivalid, inst, maddr, hit_cnt, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            en = 1'b0;
            addr = $urandom;
            #1;
            checks++;
            if (ivalid !== 1'b0 || stall !== 1'b0 || inst !== '0 || req !== 1'b0 ||
                hit_cnt !== m_hits || miss_cnt !== m_misses) begin
                errors++;
                $display("FAIL idle_no_lookup got v=%b st=%b d=%h rq=%b h=%0d m=%0d want 0 0 0 0 %0d %0d",
                         ivalid, stall, inst, req, hit_cnt, miss_cnt, m_hits, m_misses);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cold_miss();
        int s, r, rc;
        do_fetch(32'h1C00_0000, 2, 32'h0280_0421, -1, s, r, rc);
        #1;
        checks++;
        if (s != 5 || rc != 3 || r != 1) begin
            errors++;
            $display("FAIL cold_miss_timing got stall=%0d req_cyc=%0d reqs=%0d want 5 3 1", s, rc, r);
        end
        checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cold_miss_counts got m=%0d h=%0d want 1 1", miss_cnt, hit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_hit();
        int s, r, rc;
        do_fetch(32'h1C00_0000, 0, '0, -1, s, r, rc);
        #1;
        checks++;
        if (s != 0 || r != 0 || hit_cnt !== 32'd2) begin
            errors++;
            $display("FAIL hit_again got stall=%0d reqs=%0d h=%0d want 0 0 2", s, r, hit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_alias();
        int s, r, rc;
        do_fetch(32'h1C00_0100, 1, 32'h1500_0005, -1, s, r, rc);
        #1;
        checks++;
        if (r != 1 || miss_cnt !== 32'd2) begin
            errors++;
            $display("FAIL alias_fill got reqs=%0d m=%0d want 1 2", r, miss_cnt);
        end
        @(negedge clk);
        do_fetch(32'h1C00_0000, 0, 32'h0280_0421, -1, s, r, rc);
        #1;
        checks++;
        if (r != 1 || miss_cnt !== 32'd3) begin
            errors++;
            $display("FAIL alias_evict got reqs=%0d m=%0d want 1 3", r, miss_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_in_miss();
        int s, r, rc;
        logic [31:0] m0;
        m0 = m_misses;
        do_fetch(32'h1C00_0204, 2, 32'hDEAD_0001, 2, s, r, rc);
        #1;
        checks++;
        if (r != 2 || miss_cnt !== m0 + 32'd2) begin
            errors++;
            $display("FAIL flush_in_miss got reqs=%0d m=%0d want 2 %0d", r, miss_cnt, m0 + 2);
        end
        @(negedge clk);
        // Flush on the ack cycle itself must also discard the fill.
        do_fetch(32'h1C00_0304, 1, 32'hDEAD_0002, 2, s, r, rc);
        #1;
        checks++;
        if (r != 2) begin
            errors++;
            $display("FAIL flush_on_ack got reqs=%0d want 2", r);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int s, r, rc;
        do_fetch(32'h1C00_0000, 0, 32'h0280_0421, -1, s, r, rc);
        en = 1'b1;
        addr = 32'h2000_0040;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || stall !== 1'b0 || ivalid !== 1'b0 || hit_cnt !== '0 ||
            miss_cnt !== '0 || maddr !== '0) begin
            errors++;
            $display("FAIL async_reset got rq=%b st=%b v=%b h=%0d m=%0d ma=%h want all 0",
                     req, stall, ivalid, hit_cnt, miss_cnt, maddr);
        end
        model_reset();
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_fetch(32'h1C00_0000, 1, 32'h0280_0421, -1, s, r, rc);
        #1;
        checks++;
        if (r != 1 || miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_miss got reqs=%0d m=%0d h=%0d want 1 1 1", r, miss_cnt, hit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int s, r, rc;
        logic [31:0] a;
        int fc;
        int dly;
        for (int i = 0; i < 60; i++) begin
            a = {8'h40, 14'($urandom_range(0, 1)), 2'b00, 6'($urandom_range(0, 3)), 2'($urandom)};
            dly = $urandom_range(0, 3);
            fc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, dly + 1) : -1;
            do_fetch(a, dly, $urandom, fc, s, r, rc);
            if ($urandom_range(0, 3) == 0) test_idle();
        end
        #1;
        checks++;
        if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            errors++;
            $display("FAIL random_counts got h=%0d m=%0d want %0d %0d",
                     hit_cnt, miss_cnt, m_hits, m_misses);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int s, r, rc;
        do_fetch(32'h1C00_0000, 0, 32'h0280_0421, -1, s, r, rc);
        force dut.u_hit_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_hit_cnt.cnt_q;
        m_hits = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h1C00_0000, 0, 32'h0280_0421, -1, s, r, rc);
            #1;
            checks++;
            if (hit_cnt !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL hit_saturate step=%0d got %h want ffffffff", i, hit_cnt);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_cold_miss();
        test_hit();
        test_alias();
        test_flush_in_miss();
        test_async_reset();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
